// File: rtl/shared_reg_arbiter_if.sv
// Request/grant/data bundle between producers and the shared register arbiter.
interface shared_reg_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 4,
   parameter int unsigned CNT_W   = 8
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        ack;
   logic [DATA_W-1:0]         data;
   logic                      busy;
   logic [IDX_W-1:0]          last_owner;
   logic [CNT_W-1:0]          write_count;

   modport slave (
      input  req, req_data,
      output gnt, ack, data, busy, last_owner, write_count
   );

   modport master (
      output req, req_data,
      input  gnt, ack, data, busy, last_owner, write_count
   );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter giving NUM_REQ producers one-at-a-time write access
// to a single shared DATA_W-bit register; one write per IDLE/GRANT/RELEASE pass.
module shared_reg_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 4,
   parameter int unsigned CNT_W   = 8
) (
   input logic               clk,
   input logic               reset,
   shared_reg_arbiter_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

   state_e               state_q,      state_d;
   logic [IDX_W-1:0]     rr_ptr_q,     rr_ptr_d;
   logic [IDX_W-1:0]     win_q,        win_d;
   logic [NUM_REQ-1:0]   gnt_q,        gnt_d;
   logic [NUM_REQ-1:0]   ack_q,        ack_d;
   logic [DATA_W-1:0]    data_q,       data_d;
   logic [IDX_W-1:0]     last_owner_q, last_owner_d;
   logic [CNT_W-1:0]     cnt_q,        cnt_d;
   logic                 busy_q,       busy_d;
   logic [IDX_W-1:0]     pick_c;

   // First active requester at or after rr_ptr, wrapping; descending scan so the nearest wins.
   always_comb begin
      pick_c = rr_ptr_q;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         int unsigned idx;
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (bus.req[idx]) pick_c = IDX_W'(idx);
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      win_d        = win_q;
      gnt_d        = '0;
      ack_d        = '0;
      data_d       = data_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;

      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               win_d   = pick_c;
               gnt_d   = NUM_REQ'(1) << pick_c;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // A withdrawn request leaves every piece of architectural state untouched.
            if (bus.req[win_q]) begin
               data_d       = bus.req_data[int'(win_q)*DATA_W +: DATA_W];
               ack_d        = NUM_REQ'(1) << win_q;
               last_owner_d = win_q;
               cnt_d        = cnt_q + CNT_W'(1);
               rr_ptr_d     = (int'(win_q) == int'(NUM_REQ) - 1) ? '0 : win_q + IDX_W'(1);
               state_d      = RELEASE;
            end else begin
               state_d = IDLE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         win_q        <= '0;
         gnt_q        <= '0;
         ack_q        <= '0;
         data_q       <= '0;
         last_owner_q <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         win_q        <= win_d;
         gnt_q        <= gnt_d;
         ack_q        <= ack_d;
         data_q       <= data_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.ack         = ack_q;
   assign bus.data        = data_q;
   assign bus.busy        = busy_q;
   assign bus.last_owner  = last_owner_q;
   assign bus.write_count = cnt_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: main 4x4 instance plus a CNT_W=2 instance for counter wrap.
module tb_shared_reg_arbiter;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   shared_reg_arbiter_if #(.NUM_REQ(4), .DATA_W(4), .CNT_W(8)) bus ();
   shared_reg_arbiter_if #(.NUM_REQ(4), .DATA_W(4), .CNT_W(2)) bus_w ();

   shared_reg_arbiter #(.NUM_REQ(4), .DATA_W(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   shared_reg_arbiter #(.NUM_REQ(4), .DATA_W(4), .CNT_W(2)) dut_w (
      .clk(clk), .reset(reset), .bus(bus_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.req = '0;
      bus_w.req = '0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (bus.gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
      n_cmp++; if (bus.ack !== 4'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
      n_cmp++; if (bus.data !== 4'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.data); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.last_owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", bus.last_owner); end
      n_cmp++; if (bus.write_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.write_count); end
   endtask

   task automatic test_single();
      do_reset();
      bus.req = 4'b0100;
      bus.req_data = 16'h0A00;
      tick();
      n_cmp++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", bus.busy); end
      n_cmp++; if (bus.ack !== 4'b0) begin n_err++; $display("FAIL single_early_ack: got %b want 0000", bus.ack); end
      tick();
      bus.req = 4'b0000;
      n_cmp++; if (bus.ack !== 4'b0100) begin n_err++; $display("FAIL single_ack: got %b want 0100", bus.ack); end
      n_cmp++; if (bus.gnt !== 4'b0) begin n_err++; $display("FAIL single_gnt_drop: got %b want 0000", bus.gnt); end
      n_cmp++; if (bus.data !== 4'hA) begin n_err++; $display("FAIL single_data: got %h want a", bus.data); end
      n_cmp++; if (bus.last_owner !== 2'd2) begin n_err++; $display("FAIL single_owner: got %0d want 2", bus.last_owner); end
      n_cmp++; if (bus.write_count !== 8'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus.write_count); end
      tick();
      n_cmp++; if (bus.ack !== 4'b0) begin n_err++; $display("FAIL single_ack_pulse: got %b want 0000", bus.ack); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", bus.busy); end
      // rr_ptr is now 3: with everyone requesting, requester 3 must win.
      bus.req = 4'b1111;
      tick();
      n_cmp++; if (bus.gnt !== 4'b1000) begin n_err++; $display("FAIL single_rrptr: got %b want 1000", bus.gnt); end
      bus.req = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_fairness();
      logic [3:0] exp_gnt;
      do_reset();
      bus.req = 4'b1111;
      bus.req_data = 16'h4321;
      for (int n = 0; n < 5; n++) begin
         exp_gnt = 4'(1) << (n % 4);
         tick();
         n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", n, bus.gnt, exp_gnt); end
         tick();
         n_cmp++; if (bus.ack !== exp_gnt || bus.gnt !== 4'b0) begin n_err++; $display("FAIL rr_ack[%0d]: got ack %b gnt %b want ack %b gnt 0000", n, bus.ack, bus.gnt, exp_gnt); end
         n_cmp++; if (bus.data !== 4'((n % 4) + 1)) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", n, bus.data, 4'((n % 4) + 1)); end
         tick();
      end
      n_cmp++; if (bus.write_count !== 8'd5) begin n_err++; $display("FAIL rr_count: got %0d want 5", bus.write_count); end
      bus.req = 4'b0000;
   endtask

   task automatic test_ptr_wrap();
      do_reset();
      bus.req = 4'b1000;
      bus.req_data = 16'h7005;
      tick();
      tick();
      bus.req = 4'b0000;
      tick();
      bus.req = 4'b1001;
      tick();
      n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_first: got %b want 0001", bus.gnt); end
      tick();
      n_cmp++; if (bus.data !== 4'h5) begin n_err++; $display("FAIL wrap_data0: got %h want 5", bus.data); end
      tick();
      tick();
      n_cmp++; if (bus.gnt !== 4'b1000) begin n_err++; $display("FAIL wrap_second: got %b want 1000", bus.gnt); end
      tick();
      n_cmp++; if (bus.data !== 4'h7) begin n_err++; $display("FAIL wrap_data3: got %h want 7", bus.data); end
      bus.req = 4'b0000;
      tick();
   endtask

   task automatic test_withdraw();
      do_reset();
      bus.req_data = 16'h0093;
      bus.req = 4'b0001;
      tick();
      tick();
      bus.req = 4'b0000;
      tick();
      bus.req = 4'b0010;
      tick();
      n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL wd_gnt: got %b want 0010", bus.gnt); end
      bus.req = 4'b0000;
      tick();
      n_cmp++; if (bus.ack !== 4'b0) begin n_err++; $display("FAIL wd_ack: got %b want 0000", bus.ack); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wd_idle: got %b want 0", bus.busy); end
      n_cmp++; if (bus.data !== 4'h3) begin n_err++; $display("FAIL wd_data: got %h want 3", bus.data); end
      n_cmp++; if (bus.write_count !== 8'd1) begin n_err++; $display("FAIL wd_count: got %0d want 1", bus.write_count); end
      n_cmp++; if (bus.last_owner !== 2'd0) begin n_err++; $display("FAIL wd_owner: got %0d want 0", bus.last_owner); end
      bus.req = 4'b0011;
      tick();
      n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL wd_regrant: got %b want 0010", bus.gnt); end
      tick();
      n_cmp++; if (bus.data !== 4'h9) begin n_err++; $display("FAIL wd_data1: got %h want 9", bus.data); end
      bus.req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.req_data = 16'h00C0;
      bus.req = 4'b0010;
      tick();
      tick();
      tick();
      tick();
      n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL rm_in_grant: got %b want 0010", bus.gnt); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (bus.gnt !== 4'b0 || bus.ack !== 4'b0) begin n_err++; $display("FAIL rm_handshake: got gnt %b ack %b want 0000", bus.gnt, bus.ack); end
      n_cmp++; if (bus.data !== 4'h0) begin n_err++; $display("FAIL rm_data: got %h want 0", bus.data); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.write_count !== 8'd0) begin n_err++; $display("FAIL rm_count: got %0d want 0", bus.write_count); end
      bus.req = 4'b0000;
      tick();
      #3 reset = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         n_cmp++; if (bus.ack !== 4'b0 || bus.write_count !== 8'd0) begin n_err++; $display("FAIL rm_no_ack[%0d]: got ack %b count %0d want 0000/0", n, bus.ack, bus.write_count); end
      end
   endtask

   task automatic test_count_wrap();
      logic [1:0] exp_cnt;
      do_reset();
      bus_w.req_data = 16'h000E;
      bus_w.req = 4'b0001;
      for (int n = 0; n < 5; n++) begin
         exp_cnt = 2'((n + 1) % 4);
         tick();
         tick();
         n_cmp++; if (bus_w.write_count !== exp_cnt) begin n_err++; $display("FAIL cnt_wrap[%0d]: got %0d want %0d", n, bus_w.write_count, exp_cnt); end
         tick();
      end
      bus_w.req = 4'b0000;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      bus.req = '0;
      bus.req_data = '0;
      bus_w.req = '0;
      bus_w.req_data = '0;
      test_reset();
      test_single();
      test_fairness();
      test_ptr_wrap();
      test_withdraw();
      test_reset_mid();
      test_count_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-bit storage register between NUM_REQ requesters.
- Each requester raises req with its write data. The block grants one requester at a time, loads that requester's data into the shared register, and returns a one-cycle ack.
- Sits in front of the small state/data registers in the datapath, so several producers can update a single register without contention.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, width of the shared register and of each requester's data.
- CNT_W, 8, width of the completed-write counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req  input  NUM_REQ  per-requester write request; level, held until ack or withdrawn.
- req_data  input  NUM_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant; registered.
- ack  output  NUM_REQ  one-hot, one-cycle write-complete pulse; registered.
- data  output  DATA_W  shared register contents.
- busy  output  1  high whenever state is not IDLE.
- last_owner  output  $clog2(NUM_REQ)  index of the requester that performed the last completed write.
- write_count  output  CNT_W  number of completed writes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0.
  - gnt=0, ack=0, data=0, busy=0, last_owner=0, write_count=0.
  - Applies mid-operation: a pending write is discarded and no ack is issued.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Next edge: gnt=onehot(winner), state=GRANT, winner index held in an internal register.
- GRANT (exactly one cycle):
  - If req[winner]=1 at the edge (write completes):
    - data <= req_data slice of winner, sampled at that edge.
    - ack <= onehot(winner).
    - last_owner <= winner; write_count <= write_count+1 (wraps).
    - rr_ptr <= (winner+1) mod NUM_REQ.
    - gnt <= 0; state=RELEASE.
  - If req[winner]=0 at the edge (withdrawal):
    - No write, no ack; data, rr_ptr, write_count and last_owner unchanged.
    - gnt <= 0; state=IDLE.
  - Requests from other requesters during GRANT are ignored until the next IDLE cycle.
- RELEASE (exactly one cycle):
  - ack is high this cycle only.
  - Next edge: ack <= 0, state=IDLE.
  - The requester drops req in the ack cycle. If it does not, it is treated as a new request and re-arbitrated behind the others via rr_ptr.
- Timing:
  - Request sampled in IDLE at edge E0: gnt high after E0, data updated and ack high after E1, back in IDLE after E2.
  - Peak throughput is one write per 3 cycles.
- Invariants:
  - gnt and ack are each zero or one-hot, and never both nonzero in the same cycle.
  - data changes only on a completed write or on reset.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0,... and no requester waits more than NUM_REQ grants.
- busy = (state != IDLE); derived from registered state only, so it is glitch-free.

Test Plan:
- Reset then single request: reset=0 for 2 cycles, release; req=4'b0100, req[2] data=4'hA.
  -> gnt=4'b0100 one cycle, then data=4'hA with ack=4'b0100 one cycle; last_owner=2, write_count=1, rr_ptr=3.
- All four requesting continuously with data 1,2,3,4 for requesters 0..3.
  -> grant order 0,1,2,3,0; data sequence 1,2,3,4,1; write_count=5 after 15 cycles.
- Wrap of pointer: after a requester-3 write, req=4'b1001.
  -> requester 0 granted first, then 3.
- Withdrawal: req[1]=1 granted, req[1] dropped during GRANT.
  -> no ack, data unchanged, write_count unchanged, state returns to IDLE, and the next request from requester 1 is still served first.
- Reset mid-operation: assert reset=0 asynchronously (between clock edges) while in GRANT.
  -> gnt, ack, data, busy and write_count go to 0 immediately; no ack pulse after reset release.
- Counter wrap: with CNT_W=8 overridden to 2, perform 5 writes.
  -> write_count sequence 1,2,3,0,1.
